// File: rtl/display_pkg.sv
// Shared types and constants for the three-digit multiplexed 7-segment driver.
//   state_e    : which digit slot is being scanned (hundreds, tens, units).
//   SEG_BLANK  : all segments off (active-low).
//   SEG_E      : 'E' glyph used for non-BCD codes 10..15.
//   DIGIT_GLYPH: active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
package display_pkg;

  typedef enum logic [1:0] {
    S_CEN = 2'd0,
    S_DEZ = 2'd1,
    S_UNI = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // Index 0 is the rightmost entry of the packed array.
  localparam logic [9:0][6:0] DIGIT_GLYPH = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder.
//   digit_in : 4-bit digit; 10..15 render as 'E'.
//   blank_in : 1 forces all segments off.
//   seg_out  : segments {g,f,e,d,c,b,a}, active-low.
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] digit_in,
  input  logic       blank_in,
  output logic [6:0] seg_out
);

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    seg_out = SEG_E;
    if (blank_in) begin
      seg_out = SEG_BLANK;
    end else if (digit_in < 4'd10) begin
      seg_out = DIGIT_GLYPH[digit_in];
    end
  end

endmodule

// File: rtl/display_mux_7seg.sv
// Three-digit time-multiplexed common-anode 7-segment driver.
//   clk, rst         : clock, synchronous active-high reset.
//   en               : 0 darkens the display; scanning keeps running.
//   blank_zeros      : 1 blanks leading zeros in the hundreds/tens slots.
//   centena_in/dezena_in/unidade_in : BCD digits, snapshotted once per frame.
//   seg_out          : active-low segments {g,f,e,d,c,b,a}, registered.
//   an_out           : active-low anodes {cen,dez,uni}, registered.
//   frame_start      : high on the cycle the snapshot is taken.
// Each digit slot lasts SCAN_DIV cycles; the first GUARD cycles of every slot
// keep all anodes off to avoid ghosting between digits.
module display_mux_7seg
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GUARD    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       blank_zeros,
  input  logic [3:0] centena_in,
  input  logic [3:0] dezena_in,
  input  logic [3:0] unidade_in,
  output logic [6:0] seg_out,
  output logic [2:0] an_out,
  output logic       frame_start
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       snap_c_q, snap_c_d;
  logic [3:0]       snap_d_q, snap_d_d;
  logic [3:0]       snap_u_q, snap_u_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;

  logic             snap_take;
  logic [3:0]       sel_digit;
  logic             sel_blank;
  logic [2:0]       sel_an;
  logic [6:0]       glyph;

  assign snap_take   = (state_q == S_CEN) && (cnt_q == '0);
  // Reset wins over the snapshot, so no pulse while rst is held.
  assign frame_start = snap_take && !rst;

  // Slot counter, scan FSM and per-frame snapshot.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    snap_c_d = snap_c_q;
    snap_d_d = snap_d_q;
    snap_u_d = snap_u_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      case (state_q)
        S_CEN:   state_d = S_DEZ;
        S_DEZ:   state_d = S_UNI;
        default: state_d = S_CEN;
      endcase
    end
    if (snap_take) begin
      snap_c_d = centena_in;
      snap_d_d = dezena_in;
      snap_u_d = unidade_in;
    end
  end

  // Digit select and leading-zero blanking. The next-snapshot values are used
  // so the cycle that takes the snapshot already displays the new frame.
  always_comb begin
    sel_digit = snap_u_d;
    sel_blank = 1'b0;
    sel_an    = 3'b110;
    case (state_q)
      S_CEN: begin
        sel_digit = snap_c_d;
        sel_blank = blank_zeros && (snap_c_d == 4'd0);
        sel_an    = 3'b011;
      end
      S_DEZ: begin
        sel_digit = snap_d_d;
        sel_blank = blank_zeros && (snap_c_d == 4'd0) && (snap_d_d == 4'd0);
        sel_an    = 3'b101;
      end
      default: ;
    endcase
  end

  bcd_to_7seg u_dec (
    .digit_in (sel_digit),
    .blank_in (sel_blank),
    .seg_out  (glyph)
  );

  always_comb begin
    an_d  = 3'b111;
    seg_d = SEG_BLANK;
    if (en && (cnt_q >= CNT_GUARD)) begin
      an_d  = sel_an;
      seg_d = glyph;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // The snapshot registers are reset too, so a blanked or decoded digit is
  // well defined from the very first frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CEN;
      cnt_q    <= '0;
      snap_c_q <= 4'd0;
      snap_d_q <= 4'd0;
      snap_u_q <= 4'd0;
      seg_q    <= SEG_BLANK;
      an_q     <= 3'b111;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      snap_c_q <= snap_c_d;
      snap_d_q <= snap_d_d;
      snap_u_q <= snap_u_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign an_out  = an_q;

endmodule

// File: tb/tb_display_mux_7seg.sv
// Randomized and directed stimulus for display_mux_7seg (SCAN_DIV=8, GUARD=2)
// checked cycle by cycle against a frame/slot arithmetic model via a queue.
module tb_display_mux_7seg;

  localparam int SD = 8;
  localparam int GD = 2;
  localparam int FRAME = 3 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       blank_zeros = 1'b0;
  logic [3:0] centena_in = 4'd0;
  logic [3:0] dezena_in = 4'd0;
  logic [3:0] unidade_in = 4'd0;
  logic [6:0] seg_out;
  logic [2:0] an_out;
  logic       frame_start;

  display_mux_7seg #(.SCAN_DIV(SD), .GUARD(GD)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .blank_zeros (blank_zeros),
    .centena_in  (centena_in),
    .dezena_in   (dezena_in),
    .unidade_in  (unidade_in),
    .seg_out     (seg_out),
    .an_out      (an_out),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] an;
    logic [6:0] seg;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model state
  int         t = 0;
  logic       prev_rst = 1'b1;
  logic [3:0] snap[3];
  exp_t       pend;

  function automatic logic [6:0] ref_glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  task automatic check(input string name, input int c, input logic [7:0] act,
                       input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h required %h", name, c, act, req);
    end
  endtask

  // One clock cycle of stimulus plus the model's prediction for it.
  task automatic step(input logic r, input logic e, input logic b,
                      input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
    int slot, pos;
    exp_t cur;
    @(posedge clk);
    #1;
    rst = r; en = e; blank_zeros = b;
    centena_in = c; dezena_in = d; unidade_in = u;
    t = prev_rst ? 0 : t + 1;
    cur = pend;
    cur.fs = !r && (t % FRAME == 0);
    exp_q.push_back(cur);
    pend = '{an: 3'b111, seg: 7'h7F, fs: 1'b0};
    if (r) begin
      snap[0] = 4'd0; snap[1] = 4'd0; snap[2] = 4'd0;
    end else begin
      if (t % FRAME == 0) begin
        snap[0] = c; snap[1] = d; snap[2] = u;
      end
      slot = (t / SD) % 3;
      pos  = t % SD;
      if (e && pos >= GD) begin
        pend.an = ~(3'b100 >> slot);
        if (b && snap[0] == 4'd0 && (slot == 0 || (slot == 1 && snap[1] == 4'd0)))
          pend.seg = 7'h7F;
        else
          pend.seg = ref_glyph(snap[slot]);
      end
    end
    prev_rst = r;
    cyc++;
  endtask

  task automatic run(input int n, input logic e, input logic b,
                     input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
    for (int i = 0; i < n; i++) step(1'b0, e, b, c, d, u);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("an_out", cyc, {5'd0, an_out}, {5'd0, e.an});
        check("seg_out", cyc, {1'b0, seg_out}, {1'b0, e.seg});
        check("frame_start", cyc, {7'd0, frame_start}, {7'd0, e.fs});
      end
    end
  end

  initial begin
    logic       r_e, r_b;
    logic [3:0] r_c, r_d, r_u;
    snap[0] = 4'd0; snap[1] = 4'd0; snap[2] = 4'd0;
    pend = '{an: 3'b111, seg: 7'h7F, fs: 1'b0};

    // Reset held: outputs dark, no frame_start.
    step(1'b1, 1'b1, 1'b0, 4'd2, 4'd5, 4'd5);
    step(1'b1, 1'b1, 1'b0, 4'd2, 4'd5, 4'd5);
    // 2/5/5 scan after release.
    run(30, 1'b1, 1'b0, 4'd2, 4'd5, 4'd5);
    // Leading-zero blanking and its absence.
    step(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd7);
    run(26, 1'b1, 1'b1, 4'd0, 4'd0, 4'd7);
    run(26, 1'b1, 1'b0, 4'd0, 4'd0, 4'd7);
    // Zero hundreds, nonzero tens: only hundreds blanked.
    run(26, 1'b1, 1'b1, 4'd0, 4'd4, 4'd0);
    // Invalid hundreds shows 'E' either way.
    run(26, 1'b1, 1'b1, 4'hC, 4'd3, 4'd1);
    run(26, 1'b1, 1'b0, 4'hC, 4'hF, 4'd1);
    // Units change mid-frame only appears after the next snapshot.
    step(1'b1, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3);
    run(5, 1'b1, 1'b0, 4'd1, 4'd2, 4'd3);
    run(50, 1'b1, 1'b0, 4'd1, 4'd2, 4'd9);
    // Reset pulse mid-dezena.
    step(1'b1, 1'b1, 1'b0, 4'd8, 4'd6, 4'd4);
    run(13, 1'b1, 1'b0, 4'd8, 4'd6, 4'd4);
    step(1'b1, 1'b1, 1'b0, 4'd8, 4'd6, 4'd4);
    run(30, 1'b1, 1'b0, 4'd8, 4'd6, 4'd4);
    // Display disabled for over a frame, then re-enabled mid-frame.
    run(30, 1'b0, 1'b0, 4'd9, 4'd0, 4'd6);
    run(30, 1'b1, 1'b0, 4'd9, 4'd0, 4'd6);

    // Randomized traffic.
    r_e = 1'b1; r_b = 1'b0; r_c = 4'd0; r_d = 4'd0; r_u = 4'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r_c = 4'($urandom_range(0, 15));
        r_d = 4'($urandom_range(0, 15));
        r_u = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) r_c = 4'd0;
        if ($urandom_range(0, 2) == 0) r_d = 4'd0;
      end
      if ($urandom_range(0, 39) == 0) r_b = ~r_b;
      if ($urandom_range(0, 49) == 0) r_e = ~r_e;
      step(($urandom_range(0, 149) == 0), r_e, r_b, r_c, r_d, r_u);
    end

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
